// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch stage.
package pc_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        TRAP
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_PLUS4,
        PC_TARGET,
        PC_JALR,
        PC_RSVD
    } pc_src_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC selection: pc+4, branch/JAL target or JALR target (bit 0 cleared),
// plus the word-alignment check on the selected value.
module next_pc_sel
    import pc_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pcTarget,
    input  logic [31:0] aluResult,
    input  logic [1:0]  pcSrc,
    output logic [31:0] nextPc,
    output logic        misalign
);

    always_comb begin
        nextPc = pc + 32'd4;
        case (pc_src_e'(pcSrc))
            PC_TARGET: nextPc = pcTarget;
            PC_JALR:   nextPc = {aluResult[31:1], 1'b0};
            default:   nextPc = pc + 32'd4;
        endcase
    end

    // JALR only clears bit 0, so bit 1 can still flag a misaligned target.
    assign misalign = |nextPc[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and word-fetch FSM: requests an instruction, holds it for decode,
// advances to the selected next PC on accept, and traps on a misaligned PC.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [31:0] pcTarget,
    input  logic [31:0] aluResult,
    input  logic [1:0]  pcSrc,
    input  logic        stall,
    input  logic        instrConsume,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemRdy,
    input  logic [31:0] imemRdata,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic        misaligned
);

    fetch_state_e state_reg;
    logic [31:0]  pc_reg;
    logic [31:0]  instr_reg;
    logic         req_reg;
    logic         valid_reg;
    logic         misaligned_reg;

    logic [31:0]  pc_next;
    logic         pc_next_misalign;
    logic         accept;

    next_pc_sel u_next_pc_sel (
        .pc        (pc_reg),
        .pcTarget  (pcTarget),
        .aluResult (aluResult),
        .pcSrc     (pcSrc),
        .nextPc    (pc_next),
        .misalign  (pc_next_misalign)
    );

    // A stalled pipeline cannot take the instruction even if decode asks for it.
    assign accept = instrConsume & ~stall;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_VECTOR;
            instr_reg      <= NOP_INSTR;
            req_reg        <= 1'b0;
            valid_reg      <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            req_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    state_reg <= REQ;
                    req_reg   <= 1'b1;
                end
                REQ: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (imemRdy) begin
                        instr_reg <= imemRdata;
                        valid_reg <= 1'b1;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        pc_reg    <= pc_next;
                        valid_reg <= 1'b0;
                        if (pc_next_misalign) begin
                            misaligned_reg <= 1'b1;
                            state_reg      <= TRAP;
                        end else begin
                            req_reg   <= 1'b1;
                            state_reg <= REQ;
                        end
                    end
                end
                TRAP: begin
                    state_reg <= TRAP;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign imemReq    = req_reg;
    assign imemAddr   = pc_reg;
    assign instrValid = valid_reg;
    assign instr      = instr_reg;
    assign pc         = pc_reg;
    assign pcPlus4    = pc_reg + 32'd4;
    assign misaligned = misaligned_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised bench for pc_fetch_unit: a behavioural PC model feeds expected
// fetch addresses / instructions into queues that a monitor checks.
`timescale 1ns/1ps
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [31:0] pcTarget = '0;
    logic [31:0] aluResult = '0;
    logic [1:0]  pcSrc = '0;
    logic        stall = 1'b0;
    logic        instrConsume = 1'b0;
    logic        imemRdy = 1'b0;
    logic [31:0] imemRdata = '0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        misaligned;

    pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .pcTarget     (pcTarget),
        .aluResult    (aluResult),
        .pcSrc        (pcSrc),
        .stall        (stall),
        .instrConsume (instrConsume),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .imemRdy      (imemRdy),
        .imemRdata    (imemRdata),
        .instrValid   (instrValid),
        .instr        (instr),
        .pc           (pc),
        .pcPlus4      (pcPlus4),
        .misaligned   (misaligned)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          rdy_delay = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] addr_q[$];
    logic [31:0] pc_q[$];
    logic [31:0] exp_pc = RV;
    logic        prev_valid = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %h, expected no such event", name, act);
    endtask

    // Instruction memory: answers each request rdy_delay edges after it is taken.
    always @(negedge clk) begin
        if (!resetN) pend_cnt = 0;
        else if (imemReq) begin
            pend_addr = imemAddr;
            pend_cnt  = rdy_delay;
        end
    end

    always @(posedge clk) begin
        #1;
        imemRdy = 1'b0;
        if (!resetN) pend_cnt = 0;
        else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imemRdy   = 1'b1;
                imemRdata = mem_word(pend_addr);
            end
        end
    end

    // Monitor: every request and every newly valid instruction is checked against the model.
    always @(negedge clk) begin
        if (resetN) begin
            if (imemReq) begin
                if (addr_q.size() == 0) flag("unexpected_req", imemAddr);
                else check("fetch_addr", imemAddr, addr_q.pop_front());
            end
            if (instrValid && !prev_valid) begin
                if (pc_q.size() == 0) flag("unexpected_valid", pc);
                else begin
                    logic [31:0] e;
                    e = pc_q.pop_front();
                    check("instr", instr, mem_word(e));
                    check("pc", pc, e);
                    check("pcPlus4", pcPlus4, e + 32'd4);
                    $display("[TB] fetched pc=%h instr=%h", pc, instr);
                end
            end
        end
        prev_valid = instrValid;
    end

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instrValid && n < 60);
        if (!instrValid) flag(name, {31'd0, instrValid});
    endtask

    // Issue an accept at the next edge; model the next PC from the select rules.
    task automatic do_accept(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
        logic [31:0] nxt;
        pcSrc = src;
        pcTarget = tgt;
        aluResult = alu;
        instrConsume = 1'b1;
        stall = 1'b0;
        case (src)
            2'd1:    nxt = tgt;
            2'd2:    nxt = alu & 32'hFFFF_FFFE;
            default: nxt = exp_pc + 32'd4;
        endcase
        if (nxt[1:0] == 2'b00) begin
            addr_q.push_back(nxt);
            pc_q.push_back(nxt);
        end
        exp_pc = nxt;
        @(posedge clk);
        #1;
        instrConsume = 1'b0;
        pcSrc = 2'($urandom);
        pcTarget = $urandom;
        aluResult = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        time         t0;
        int          reqs;
        int          n;
        logic [31:0] r;
        logic [31:0] tgt;
        logic [31:0] alu;

        resetN = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pc", pc, RV);
        check("rst_pcPlus4", pcPlus4, RV + 32'd4);
        check("rst_imemAddr", imemAddr, RV);
        check("rst_imemReq", {31'd0, imemReq}, 32'd0);
        check("rst_instrValid", {31'd0, instrValid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_misaligned", {31'd0, misaligned}, 32'd0);

        rdy_delay = 2;
        addr_q.push_back(RV);
        pc_q.push_back(RV);
        resetN = 1'b1;
        @(negedge clk);
        check("first_req", {31'd0, imemReq}, 32'd1);
        wait_valid("first_valid_timeout");
        check("first_instr", instr, 32'h0050_0093);

        // Sequential flow with one-cycle memory: one instruction every 3 cycles.
        rdy_delay = 1;
        repeat (2) begin
            t0 = $time;
            do_accept(2'd0, 32'd0, 32'd0);
            wait_valid("seq_valid_timeout");
            check("seq_period", 32'(($time - t0) / 10), 32'd3);
        end

        do_accept(2'd1, 32'h0000_0200, 32'd0);
        wait_valid("branch_valid_timeout");
        do_accept(2'd2, 32'd0, 32'h0000_0301);
        wait_valid("jalr_valid_timeout");
        check("jalr_pc", pc, 32'h0000_0300);
        check("jalr_misaligned", {31'd0, misaligned}, 32'd0);

        // Stall beats instrConsume: everything must hold for 5 cycles.
        stall = 1'b1;
        instrConsume = 1'b1;
        pcSrc = 2'd1;
        pcTarget = 32'h0000_0040;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", {31'd0, instrValid}, 32'd1);
            check("stall_pc", pc, exp_pc);
            check("stall_req", {31'd0, imemReq}, 32'd0);
        end
        stall = 1'b0;
        instrConsume = 1'b0;

        // Slow memory: instrValid must rise exactly one cycle after imemRdy.
        rdy_delay = 7;
        do_accept(2'd0, 32'd0, 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imemRdy && n < 30);
        check("late_rdy_seen", {31'd0, imemRdy}, 32'd1);
        check("late_valid_before", {31'd0, instrValid}, 32'd0);
        @(negedge clk);
        check("late_valid_after", {31'd0, instrValid}, 32'd1);

        // Randomised flow with occasional stalls and variable memory latency.
        for (int i = 0; i < 24; i++) begin
            rdy_delay = $urandom_range(1, 4);
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                stall = 1'b1;
                instrConsume = 1'b1;
                @(negedge clk);
            end
            r = $urandom;
            tgt = r & 32'hFFFF_FFFC;
            r = $urandom;
            alu = (r & 32'hFFFF_FFFC) | {31'd0, r[0]};
            do_accept(2'($urandom_range(0, 3)), tgt, alu);
            wait_valid("rand_valid_timeout");
        end

        // Wrap at the top of the address space.
        rdy_delay = 1;
        do_accept(2'd1, 32'hFFFF_FFFC, 32'd0);
        wait_valid("wrap_top_timeout");
        do_accept(2'd0, 32'd0, 32'd0);
        wait_valid("wrap_zero_timeout");
        check("wrap_pc", pc, 32'h0000_0000);

        // Asynchronous reset while waiting on memory.
        rdy_delay = 6;
        do_accept(2'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        check("arst_req", {31'd0, imemReq}, 32'd0);
        check("arst_valid", {31'd0, instrValid}, 32'd0);
        check("arst_pc", pc, RV);
        @(negedge clk);
        addr_q.delete();
        pc_q.delete();
        rdy_delay = 1;
        exp_pc = RV;
        addr_q.push_back(RV);
        pc_q.push_back(RV);
        resetN = 1'b1;
        wait_valid("arst_refetch_timeout");

        // Misaligned branch target traps until reset.
        do_accept(2'd1, 32'h0000_0202, 32'd0);
        @(negedge clk);
        check("trap_misaligned", {31'd0, misaligned}, 32'd1);
        check("trap_valid", {31'd0, instrValid}, 32'd0);
        check("trap_pc", pc, 32'h0000_0202);
        reqs = 0;
        repeat (20) begin
            @(negedge clk);
            reqs += int'(imemReq);
        end
        check("trap_no_req", 32'(reqs), 32'd0);
        #2;
        resetN = 1'b0;
        #1;
        check("trap_reset_clears", {31'd0, misaligned}, 32'd0);
        @(negedge clk);
        exp_pc = RV;
        addr_q.push_back(RV);
        pc_q.push_back(RV);
        resetN = 1'b1;
        wait_valid("post_trap_timeout");

        // JALR: bit 0 is cleared but bit 1 still traps.
        do_accept(2'd2, 32'd0, 32'h0000_0303);
        @(negedge clk);
        check("jalr_trap_misaligned", {31'd0, misaligned}, 32'd1);
        check("jalr_trap_pc", pc, 32'h0000_0302);
        repeat (3) @(negedge clk);
        check("queues_drained", 32'(addr_q.size() + pc_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
